// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point datapath types and constants
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 24;

   localparam logic [1:0] RM_NEAR_EVEN = 2'd0;
   localparam logic [1:0] RM_ZERO      = 2'd1;
   localparam logic [1:0] RM_POS_INF   = 2'd2;
   localparam logic [1:0] RM_NEG_INF   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fp_normalize.sv
// rtl/fp_normalize.sv - iterative one-bit-per-cycle left normalizer ahead of the rounder
module fp_normalize #(
   parameter int DATA_W  = 32,
   parameter int EXP_W   = fp_pkg::EXP_W,
   parameter int SHIFT_W = $clog2(DATA_W) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [EXP_W-1:0]   in_exp,
   input  logic               in_sign,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [EXP_W-1:0]   out_exp,
   output logic               out_sign,
   output logic [1:0]         out_mode,
   output logic [SHIFT_W-1:0] out_shift,
   output logic               out_zero,
   output logic               out_denorm
);

   import fp_pkg::*;

   state_t             state_q;
   state_t             state_d;
   logic [DATA_W-1:0]  data_q;
   logic [EXP_W-1:0]   exp_q;
   logic               sign_q;
   logic [1:0]         mode_q;
   logic [SHIFT_W-1:0] shift_q;
   logic               zero_q;
   logic               denorm_q;

   logic data_is_zero;
   logic hidden_set;
   logic exp_is_zero;

   assign data_is_zero = (data_q == '0);
   assign hidden_set   = data_q[DATA_W-1];
   assign exp_is_zero  = (exp_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Any of the three stop conditions ends the shift phase; flags are set in the datapath.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
         ST_SHIFT: if (data_is_zero || hidden_set || exp_is_zero) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         mode_q   <= 2'd0;
         shift_q  <= '0;
         zero_q   <= 1'b0;
         denorm_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  exp_q    <= in_exp;
                  sign_q   <= in_sign;
                  mode_q   <= in_mode;
                  shift_q  <= '0;
                  zero_q   <= 1'b0;
                  denorm_q <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // Hidden-bit test outranks the exponent test, so a value that
               // normalizes exactly as exp hits 0 is not flagged denormal.
               if (data_is_zero) begin
                  zero_q <= 1'b1;
                  exp_q  <= '0;
               end else if (hidden_set) begin
                  data_q <= data_q;
               end else if (exp_is_zero) begin
                  denorm_q <= 1'b1;
               end else begin
                  data_q  <= {data_q[DATA_W-2:0], 1'b0};
                  exp_q   <= exp_q - EXP_W'(1);
                  shift_q <= shift_q + SHIFT_W'(1);
               end
            end
            default: begin
               data_q <= data_q;
            end
         endcase
      end
   end

   assign out_data   = data_q;
   assign out_exp    = exp_q;
   assign out_sign   = sign_q;
   assign out_mode   = mode_q;
   assign out_shift  = shift_q;
   assign out_zero   = zero_q;
   assign out_denorm = denorm_q;

endmodule
